// File: rtl/hsv_adjust_pipe_if.sv
// hsv_adjust_pipe_if: pixel, control and clip-statistics bundle for the
// S/V adjust stage between the RGB->HSV and HSV->RGB converters.
//   ctrl_s/ctrl_v : sign-magnitude percent gains (MSB=1 decrease)
//   bypass        : pass S/V unchanged (sampled with controls at sof)
//   in_*          : valid-qualified input pixel, in_sof marks frame start
//   out_*         : same pixel four cycles later with adjusted S/V
//   clip_count(_vld): clipped-pixel count of the previous frame + pulse
// master = pixel source / control side, slave = the adjuster.
interface hsv_adjust_pipe_if #(
  parameter int H_W    = 9,
  parameter int S_W    = 11,
  parameter int V_W    = 8,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 22
);
  logic [CTRL_W-1:0] ctrl_s;
  logic [CTRL_W-1:0] ctrl_v;
  logic              bypass;
  logic              in_valid;
  logic              in_sof;
  logic [H_W-1:0]    in_h;
  logic [S_W-1:0]    in_s;
  logic [V_W-1:0]    in_v;
  logic              out_valid;
  logic              out_sof;
  logic [H_W-1:0]    out_h;
  logic [S_W-1:0]    out_s;
  logic [V_W-1:0]    out_v;
  logic [CNT_W-1:0]  clip_count;
  logic              clip_count_vld;

  modport master (
    output ctrl_s, ctrl_v, bypass, in_valid, in_sof, in_h, in_s, in_v,
    input  out_valid, out_sof, out_h, out_s, out_v, clip_count, clip_count_vld
  );

  modport slave (
    input  ctrl_s, ctrl_v, bypass, in_valid, in_sof, in_h, in_s, in_v,
    output out_valid, out_sof, out_h, out_s, out_v, clip_count, clip_count_vld
  );
endinterface

// File: rtl/hsv_adjust_pipe.sv
// hsv_adjust_pipe: 4-stage saturating percentage gain on S and V.
//   clk  : pixel clock
//   rst  : asynchronous reset, active-high (deassertion synchronised inside)
//   bus  : hsv_adjust_pipe_if.slave (controls, input pixel, output pixel,
//          per-frame clip count)
// Controls are shadowed at frame start so a frame never mixes two settings.
// Stages: S1 register pixel+controls, S2 multiply, S3 divide by 100,
// S4 add/subtract with clamp. H/sof/valid ride a matching delay line.
module hsv_adjust_pipe #(
  parameter int H_W    = 9,
  parameter int S_W    = 11,
  parameter int V_W    = 8,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 22
) (
  input logic              clk,
  input logic              rst,
  hsv_adjust_pipe_if.slave bus
);
  localparam int STAGES = 4;
  localparam int MAG_W  = CTRL_W - 1;
  localparam int PS_W   = S_W + MAG_W;
  localparam int PV_W   = V_W + MAG_W;
  localparam logic [PS_W:0] S_MAX = {{(PS_W+1-S_W){1'b0}}, {S_W{1'b1}}};
  localparam logic [PV_W:0] V_MAX = {{(PV_W+1-V_W){1'b0}}, {V_W{1'b1}}};

  // Async assert, release two clocks after rst drops.
  logic [1:0] rst_sr;
  logic       rst_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) rst_sr <= 2'b11;
    else     rst_sr <= {rst_sr[0], 1'b0};
  assign rst_i = rst_sr[1];

  // Shadow controls; the sof pixel itself already uses the new values.
  logic              load;
  logic [CTRL_W-1:0] sh_s, sh_v;
  logic              sh_byp;
  assign load = bus.in_valid && bus.in_sof;

  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      sh_s <= '0; sh_v <= '0; sh_byp <= 1'b0;
    end else if (load) begin
      sh_s <= bus.ctrl_s; sh_v <= bus.ctrl_v; sh_byp <= bus.bypass;
    end

  // Stage registers
  logic [S_W-1:0]    s1_s, s2_s, s3_s;
  logic [V_W-1:0]    s1_v, s2_v, s3_v;
  logic [CTRL_W-1:0] s1_cs, s1_cv;
  logic              s1_byp, s2_byp, s3_byp;
  logic              s2_ng_s, s2_ng_v, s3_ng_s, s3_ng_v;
  logic [PS_W-1:0]   s2_ps, s3_ds;
  logic [PV_W-1:0]   s2_pv, s3_dv;
  logic              clip_q;

  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      s1_s <= '0; s1_v <= '0; s1_cs <= '0; s1_cv <= '0; s1_byp <= 1'b0;
      s2_s <= '0; s2_v <= '0; s2_ps <= '0; s2_pv <= '0;
      s2_ng_s <= 1'b0; s2_ng_v <= 1'b0; s2_byp <= 1'b0;
      s3_s <= '0; s3_v <= '0; s3_ds <= '0; s3_dv <= '0;
      s3_ng_s <= 1'b0; s3_ng_v <= 1'b0; s3_byp <= 1'b0;
    end else begin
      s1_s   <= bus.in_s;
      s1_v   <= bus.in_v;
      s1_cs  <= load ? bus.ctrl_s : sh_s;
      s1_cv  <= load ? bus.ctrl_v : sh_v;
      s1_byp <= load ? bus.bypass : sh_byp;

      s2_s    <= s1_s;
      s2_v    <= s1_v;
      s2_ps   <= PS_W'(s1_s) * PS_W'(s1_cs[MAG_W-1:0]);
      s2_pv   <= PV_W'(s1_v) * PV_W'(s1_cv[MAG_W-1:0]);
      s2_ng_s <= s1_cs[MAG_W];
      s2_ng_v <= s1_cv[MAG_W];
      s2_byp  <= s1_byp;

      // Constant divisor: exact floor for any width.
      s3_s    <= s2_s;
      s3_v    <= s2_v;
      s3_ds   <= s2_ps / PS_W'(100);
      s3_dv   <= s2_pv / PV_W'(100);
      s3_ng_s <= s2_ng_s;
      s3_ng_v <= s2_ng_v;
      s3_byp  <= s2_byp;
    end

  // S4: D can exceed the channel range, so the sum is kept at full
  // product width plus one bit before clamping.
  logic [PS_W:0]  sum_s;
  logic [PV_W:0]  sum_v;
  logic           up_s, dn_s, up_v, dn_v, clip_s, clip_v;
  logic [S_W-1:0] res_s;
  logic [V_W-1:0] res_v;

  always_comb begin
    sum_s  = {1'b0, PS_W'(s3_s)} + {1'b0, s3_ds};
    sum_v  = {1'b0, PV_W'(s3_v)} + {1'b0, s3_dv};
    up_s   = sum_s > S_MAX;
    up_v   = sum_v > V_MAX;
    dn_s   = s3_ds > PS_W'(s3_s);
    dn_v   = s3_dv > PV_W'(s3_v);
    res_s  = s3_s;
    res_v  = s3_v;
    clip_s = 1'b0;
    clip_v = 1'b0;
    if (!s3_byp) begin
      // When not clamping low, D <= X so its low bits are all of D.
      if (s3_ng_s) res_s = dn_s ? '0 : s3_s - s3_ds[S_W-1:0];
      else         res_s = up_s ? '1 : sum_s[S_W-1:0];
      if (s3_ng_v) res_v = dn_v ? '0 : s3_v - s3_dv[V_W-1:0];
      else         res_v = up_v ? '1 : sum_v[V_W-1:0];
      clip_s = s3_ng_s ? dn_s : up_s;
      clip_v = s3_ng_v ? dn_v : up_v;
    end
  end

  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      bus.out_s <= '0; bus.out_v <= '0; clip_q <= 1'b0;
    end else begin
      bus.out_s <= res_s;
      bus.out_v <= res_v;
      clip_q    <= clip_s || clip_v;
    end

  // Valid / sof / hue delay line, matched to the data stages.
  logic [STAGES:1]          vld_pipe, sof_pipe;
  logic [STAGES:1][H_W-1:0] h_pipe;

  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      vld_pipe <= '0; sof_pipe <= '0; h_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      sof_pipe <= {sof_pipe[STAGES-1:1], bus.in_sof};
      h_pipe   <= {h_pipe[STAGES-1:1], bus.in_h};
    end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_sof   = sof_pipe[STAGES];
  assign bus.out_h     = h_pipe[STAGES];

  // Per-frame clip counter: the sof pixel closes the previous frame and
  // seeds the new one with its own clip flag.
  logic [CNT_W-1:0] running;

  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      running <= '0; bus.clip_count <= '0; bus.clip_count_vld <= 1'b0;
    end else if (bus.out_valid && bus.out_sof) begin
      bus.clip_count     <= running;
      bus.clip_count_vld <= 1'b1;
      running            <= CNT_W'(clip_q);
    end else begin
      bus.clip_count_vld <= 1'b0;
      if (bus.out_valid && clip_q && running != '1)
        running <= running + CNT_W'(1);
    end
endmodule

// File: tb/tb_hsv_adjust_pipe.sv
module tb_hsv_adjust_pipe;
  localparam int H_W = 9, S_W = 11, V_W = 8, CTRL_W = 9, CNT_W = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hsv_adjust_pipe_if #(.H_W(H_W), .S_W(S_W), .V_W(V_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();
  hsv_adjust_pipe #(.H_W(H_W), .S_W(S_W), .V_W(V_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int cyc; int sof; int h; int s; int v;} px_t;
  typedef struct {int cyc; int cnt;} cnt_t;
  px_t  exp_q[$];
  cnt_t cnt_q[$];

  int cyc = 0, errors = 0, checks = 0;
  int sh_s = 0, sh_v = 0, sh_b = 0, run_clip = 0;

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: percent gain with exact integer floor, then clamp.
  function automatic void adj(input int x, input int ctrl, input int w, output int r, output int clip);
    int mag, d, mx;
    mag = ctrl % 256;
    d   = (x * mag) / 100;
    mx  = (1 << w) - 1;
    if (ctrl >= 256) begin
      r = x - d; clip = (r < 0) ? 1 : 0; if (r < 0) r = 0;
    end else begin
      r = x + d; clip = (r > mx) ? 1 : 0; if (r > mx) r = mx;
    end
  endfunction

  task automatic drive(input int vld, input int sof, input int h, input int s, input int v,
                       input int cs, input int cv, input int byp);
    int rs, rv, c1, c2, cl;
    px_t p;
    cnt_t c;
    @(posedge clk); #1;
    bus.in_valid = 1'(vld);
    bus.in_sof   = 1'(sof);
    bus.in_h     = H_W'(h);
    bus.in_s     = S_W'(s);
    bus.in_v     = V_W'(v);
    bus.ctrl_s   = CTRL_W'(cs);
    bus.ctrl_v   = CTRL_W'(cv);
    bus.bypass   = 1'(byp);
    if (vld != 0) begin
      if (sof != 0) begin
        sh_s = cs; sh_v = cv; sh_b = byp;
        c.cyc = cyc + 5; c.cnt = run_clip;
        cnt_q.push_back(c);
      end
      if (sh_b != 0) begin
        rs = s; rv = v; c1 = 0; c2 = 0;
      end else begin
        adj(s, sh_s, S_W, rs, c1);
        adj(v, sh_v, V_W, rv, c2);
      end
      p.cyc = cyc + 4; p.sof = sof; p.h = h; p.s = rs; p.v = rv;
      exp_q.push_back(p);
      cl = (c1 != 0 || c2 != 0) ? 1 : 0;
      if (sof != 0) run_clip = cl; else run_clip += cl;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete(); cnt_q.delete();
    sh_s = 0; sh_v = 0; sh_b = 0; run_clip = 0;
    #1;
    chk("rst_out_valid_immediate", bus.out_valid, 0);
    chk("rst_clip_vld_immediate", bus.clip_count_vld, 0);
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
  endtask

  // Monitor / scoreboard
  initial begin
    px_t e;
    cnt_t c;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("out_valid_during_reset", bus.out_valid, 0);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_pixel: not observed, expected at cycle %0d s=%0d v=%0d", e.cyc, e.s, e.v);
        end
        while (cnt_q.size() > 0 && cnt_q[0].cyc < cyc) begin
          c = cnt_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_clip_pulse: not observed, expected at cycle %0d count=%0d", c.cyc, c.cnt);
        end
        if (bus.out_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pixel: got out_valid at cycle %0d, expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.sof != int'(bus.out_sof) || e.h != int'(bus.out_h) ||
                e.s != int'(bus.out_s) || e.v != int'(bus.out_v)) begin
              errors++;
              $display("FAIL pixel: got cyc=%0d sof=%0d h=%0d s=%0d v=%0d expected cyc=%0d sof=%0d h=%0d s=%0d v=%0d",
                       cyc, bus.out_sof, bus.out_h, bus.out_s, bus.out_v, e.cyc, e.sof, e.h, e.s, e.v);
            end
          end
        end
        if (bus.clip_count_vld) begin
          checks++;
          if (cnt_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_clip_pulse: got count=%0d at cycle %0d, expected none", bus.clip_count, cyc);
          end else begin
            c = cnt_q.pop_front();
            if (c.cyc != cyc || c.cnt != int'(bus.clip_count)) begin
              errors++;
              $display("FAIL clip_count: got cyc=%0d count=%0d expected cyc=%0d count=%0d",
                       cyc, bus.clip_count, c.cyc, c.cnt);
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_h = '0; bus.in_s = '0; bus.in_v = '0;
    bus.ctrl_s = '0; bus.ctrl_v = '0; bus.bypass = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_sof", bus.out_sof, 0);
    chk("reset_out_h", bus.out_h, 0);
    chk("reset_out_s", bus.out_s, 0);
    chk("reset_out_v", bus.out_v, 0);
    chk("reset_clip_count", bus.clip_count, 0);
    chk("reset_clip_count_vld", bus.clip_count_vld, 0);
    rst = 1'b0;
    idle(3);

    // Directed cases
    drive(1, 1, 11, 1000, 100, 'h032, 'h000, 0);  // 1500 / 100
    drive(1, 1, 12, 1800, 10, 'h032, 'h1FF, 0);   // 2047 / 0, clips once
    drive(1, 1, 13, 7, 0, 'h121, 'h000, 0);       // 5, reports 1
    drive(1, 1, 14, 0, 200, 'h000, 'h00A, 0);     // 220
    drive(1, 0, 15, 0, 200, 'h000, 'h014, 0);     // still +10%
    drive(0, 0, 0, 0, 0, 'h000, 'h014, 0);
    drive(1, 0, 16, 0, 200, 'h000, 'h014, 0);
    drive(1, 1, 17, 0, 200, 'h000, 'h014, 0);     // 240
    idle(6);

    // Magnitude sweep both signs with boundary S/V values
    for (int sg = 0; sg < 2; sg++)
      for (int m = 0; m < 256; m++) begin
        drive(1, 1, $urandom_range(511), $urandom_range(2047), $urandom_range(255),
              sg * 256 + m, (1 - sg) * 256 + m, 0);
        drive(1, 0, $urandom_range(511), 0, 255, $urandom_range(511), $urandom_range(511), 1);
        drive(1, 0, $urandom_range(511), 2047, 0, 0, 0, 0);
        drive(1, 0, $urandom_range(511), $urandom_range(2047), $urandom_range(255), 0, 0, 0);
      end

    // Bypass with random gaps and churning controls
    drive(1, 1, 1, 2047, 255, 'h0FF, 'h0FF, 1);
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(3) != 0) ? 1 : 0, ($urandom_range(9) == 0) ? 1 : 0,
            $urandom_range(511), $urandom_range(2047), $urandom_range(255),
            $urandom_range(511), $urandom_range(511), 1);
    idle(6);

    // Reset with three pixels in flight
    drive(1, 1, 21, 2000, 250, 'h032, 'h032, 0);
    drive(1, 0, 22, 2000, 250, 'h032, 'h032, 0);
    drive(1, 0, 23, 2000, 250, 'h032, 'h032, 0);
    do_reset(2);
    drive(1, 0, 24, 2000, 250, 'h1FF, 'h0FF, 0);  // zero shadows: pass-through
    drive(1, 0, 25, 5, 3, 'h1FF, 'h0FF, 0);
    drive(1, 1, 26, 1000, 100, 'h032, 'h000, 0);  // reports 0
    idle(6);

    // Fully random traffic
    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(9) < 7) ? 1 : 0, ($urandom_range(9) == 0) ? 1 : 0,
            $urandom_range(511), $urandom_range(2047), $urandom_range(255),
            $urandom_range(511), $urandom_range(511), ($urandom_range(4) == 0) ? 1 : 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);

    idle(12);
    chk("pixel_queue_drained", exp_q.size(), 0);
    chk("count_queue_drained", cnt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hsv_adjust_pipe.md
Name: hsv_adjust_pipe

Overview:
Parametrised, valid-qualified successor to the fixed S/V percentage adjuster in the RGB→HSV→RGB path.
- Applies signed percentage gain to S and V per pixel and saturates both ends; earlier behaviour wrapped on underflow.
- Takes new control values only at frame start, so a frame is never split between two settings.
- Counts clipped pixels per frame.
- Sits between the RGB→HSV converter and the HSV→RGB converter.

Parameters:
H_W, 9, hue width (passed through unchanged)
S_W, 11, saturation width
V_W, 8, value width
CTRL_W, 9, control width, sign-magnitude: MSB = 1 means decrease, low CTRL_W-1 bits = percent magnitude
CNT_W, 22, clip counter width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
ctrl_s  in  CTRL_W  S adjustment control (sign-magnitude percent)
ctrl_v  in  CTRL_W  V adjustment control (sign-magnitude percent)
bypass  in  1  1 = S/V pass unchanged; sampled with controls
in_valid  in  1  input pixel valid
in_sof  in  1  first pixel of frame, qualified by in_valid
in_h  in  H_W  hue
in_s  in  S_W  saturation
in_v  in  V_W  value
out_valid  out  1  output pixel valid
out_sof  out  1  delayed in_sof
out_h  out  H_W  delayed hue
out_s  out  S_W  adjusted saturation
out_v  out  V_W  adjusted value
clip_count  out  CNT_W  clipped-pixel count of the previous frame
clip_count_vld  out  1  one-cycle pulse when clip_count updates

Behaviour:
- Reset (async assert, sync deassert internally) clears the following to 0: out_valid, out_sof, out_h, out_s, out_v, clip_count, clip_count_vld, running counter, all pipeline valids, shadow controls, shadow bypass. A zero shadow control means no change.
- Shadow load: when in_valid && in_sof, load ctrl_s, ctrl_v and bypass into the shadows. That pixel and all later pixels use the new values. Controls that change at any other time are ignored until the next sof.
- Pipeline: fixed 4 cycles, no backpressure. in_valid at cycle N gives out_valid at N+4.
  - in_valid=0 bubbles propagate as bubbles.
  - H, sof and valid ride the same 4-stage delay.
  - Output data is don't-care while out_valid=0, but registers still update.
- Stages:
  - S1: register the pixel and the selected shadow controls.
  - S2: P = X * mag, full width S_W+CTRL_W-1 (V_W+CTRL_W-1 for V).
  - S3: D = floor(P / 100), exact for every input. A reciprocal multiply is allowed, e.g. P*1342178 >> 27, which is exact for the default widths; the designer proves exactness for the chosen widths.
  - S4: sign=0 gives X + D, saturating to 2^W-1. sign=1 gives X − D, saturating to 0. Compute one extra bit wide before clamping.
- mag ≥ 100 with sign=1 always gives 0. mag = 0 gives output = input.
- bypass=1: out_s = in_s and out_v = in_v at the same 4-cycle latency; clip flags are 0.
- Clip flag: set at S4 when S or V saturated, in either direction. A pixel that clips on both channels counts once.
- Counter:
  - running += 1 on out_valid && clip. Saturates at 2^CNT_W-1.
  - On out_valid && out_sof: clip_count <= running value before this pixel, clip_count_vld = 1 for one cycle, running <= this pixel's clip flag.
  - The first sof after reset reports 0.
- Reset mid-frame: pipeline is flushed and no partial pixels appear. Pixels before the next sof use zero controls (pass-through).
- Back-to-back sof (1-pixel frames) is legal. The counter reports every frame.

Test Plan:
- ctrl_s=0x032 (+50%), sof then S=1000, V=100, ctrl_v=0 → 4 cycles later out_s=1500, out_v=100, no clip.
- ctrl_s=0x032, S=1800 → out_s=2047 (clipped). ctrl_v=0x1FF (−255%), V=10 → out_v=0. Next sof → clip_count=1, clip_count_vld pulse.
- ctrl_s=0x121 (−33%), S=7 → D=floor(231/100)=2, out_s=5. Sweep all S × all magnitudes against the exact floor(X*mag/100) reference model.
- ctrl_v changed from 0x00A to 0x014 mid-frame → remaining pixels still use +10% (V=200 → 220). After the next sof, V=200 → 240.
- Random in_valid gaps with bypass=1 → out equals in delayed exactly 4 cycles; valid/sof pattern preserved; clip_count=0.
- Assert rst mid-frame with 3 pixels in flight → out_valid=0 immediately, no stale pixels emerge. First sof after release → clip_count=0.
